// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents: opcode constants used for source-operand decode, the controller
// state encoding, forward-select bit positions, and a helper function that
// extracts the register sources read by the instruction in ID.
package hazard_ctrl_pkg;

   // Opcodes that need individual decode; every 0xxx opcode is a
   // register-register ALU operation and is recognised by its top bit.
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [2:0] OP_BR_PFX = 3'b101;   // B / BR share this prefix

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDUSE   = 2'd1,
      MEMWAIT = 2'd2,
      HALT    = 2'd3
   } state_t;

   // Forward select: one-hot over the bypass sources, top bit reserved.
   localparam int FWD_W       = 3;
   localparam int FWD_WB_BIT  = 0;   // WB write data
   localparam int FWD_MEM_BIT = 1;   // MEM-stage ALU result
   typedef logic [FWD_W-1:0] fwd_sel_t;

   typedef struct packed {
      logic [3:0] a;
      logic       a_vld;
      logic [3:0] b;
      logic       b_vld;
   } src_t;

   function automatic src_t decode_src(input logic [15:0] instr);
      src_t       s;
      logic [3:0] op;
      op = instr[15:12];
      s  = '0;
      if (!op[3]) begin
         s.a     = instr[7:4];
         s.a_vld = 1'b1;
         s.b     = instr[3:0];
         s.b_vld = 1'b1;
      end else if (op == OP_LW) begin
         s.a     = instr[7:4];
         s.a_vld = 1'b1;
      end else if (op == OP_SW) begin
         s.a     = instr[7:4];
         s.a_vld = 1'b1;
         s.b     = instr[11:8];
         s.b_vld = 1'b1;
      end else if (op[3:1] == OP_BR_PFX) begin
         s.a     = instr[11:8];
         s.a_vld = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-status inputs and stall/forward controls exchanged
// between the pipeline datapath and the hazard controller.
// Inputs to the controller : ID_instr, EX_rd, MEM_rd, EX_RegWrite,
//                            MEM_RegWrite, EX_MemRead, WB_halt,
//                            branch_taken, mem_busy
// Outputs from controller  : ForwardA, ForwardB, pc_write, ifid_write,
//                            ifid_flush, idex_bubble, halted, stall_cnt
// master = datapath side, slave = controller side.
interface hazard_ctrl_if;
   logic [15:0] ID_instr;
   logic [3:0]  EX_rd;
   logic [3:0]  MEM_rd;
   logic        EX_RegWrite;
   logic        MEM_RegWrite;
   logic        EX_MemRead;
   logic        WB_halt;
   logic        branch_taken;
   logic        mem_busy;
   logic [2:0]  ForwardA;
   logic [2:0]  ForwardB;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        halted;
   logic [15:0] stall_cnt;

   modport master (
      output ID_instr, EX_rd, MEM_rd, EX_RegWrite, MEM_RegWrite, EX_MemRead,
             WB_halt, branch_taken, mem_busy,
      input  ForwardA, ForwardB, pc_write, ifid_write, ifid_flush,
             idex_bubble, halted, stall_cnt
   );

   modport slave (
      input  ID_instr, EX_rd, MEM_rd, EX_RegWrite, MEM_RegWrite, EX_MemRead,
             WB_halt, branch_taken, mem_busy,
      output ForwardA, ForwardB, pc_write, ifid_write, ifid_flush,
             idex_bubble, halted, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-select generator for a single ALU operand.
// Ports: src/src_vld      - register read by the ID instruction and whether
//                           that operand exists
//        ex_rd/ex_reg_write, mem_rd/mem_reg_write - producers in EX / MEM
//        sel              - one-hot bypass select (EX result wins over MEM)
module hazard_fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [3:0] src,
   input  logic       src_vld,
   input  logic [3:0] ex_rd,
   input  logic       ex_reg_write,
   input  logic [3:0] mem_rd,
   input  logic       mem_reg_write,
   output fwd_sel_t   sel
);

   logic dep;

   // R0 is hardwired, so it is never a real dependency.
   assign dep = src_vld & (src != 4'd0);

   always_comb begin
      sel = '0;
      if (dep && ex_reg_write && (ex_rd == src)) begin
         sel[FWD_MEM_BIT] = 1'b1;
      end else if (dep && mem_reg_write && (mem_rd == src)) begin
         sel[FWD_WB_BIT] = 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, memory
// wait, branch flush and halt handling.
// Ports: clk - clock; rst - synchronous active-high reset
//        bus - hazard_ctrl_if.slave (pipeline status in, controls out)
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave bus
);

   src_t      src;
   fwd_sel_t  sel_a;
   fwd_sel_t  sel_b;
   logic      load_use;
   state_t    state;
   state_t    state_nxt;
   fwd_sel_t  fwd_a_p1;
   fwd_sel_t  fwd_b_p1;
   logic [15:0] stall_cnt_q;
   logic      pc_write;
   logic      ifid_write;
   logic      ifid_flush;
   logic      idex_bubble;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign src = decode_src(bus.ID_instr);

   hazard_fwd_sel u_fwd_a (
      .src           (src.a),
      .src_vld       (src.a_vld),
      .ex_rd         (bus.EX_rd),
      .ex_reg_write  (bus.EX_RegWrite),
      .mem_rd        (bus.MEM_rd),
      .mem_reg_write (bus.MEM_RegWrite),
      .sel           (sel_a)
   );

   hazard_fwd_sel u_fwd_b (
      .src           (src.b),
      .src_vld       (src.b_vld),
      .ex_rd         (bus.EX_rd),
      .ex_reg_write  (bus.EX_RegWrite),
      .mem_rd        (bus.MEM_rd),
      .mem_reg_write (bus.MEM_RegWrite),
      .sel           (sel_b)
   );

   // A load in EX whose destination is read in ID; R0 never counts.
   assign load_use = bus.EX_MemRead &
                     ((src.a_vld & (src.a != 4'd0) & (src.a == bus.EX_rd)) |
                      (src.b_vld & (src.b != 4'd0) & (src.b == bus.EX_rd)));

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.WB_halt) begin
         state_nxt = HALT;
      end else begin
         case (state)
            HALT:    state_nxt = HALT;
            // A load-use bubble is only ever one cycle long.
            LDUSE:   state_nxt = bus.mem_busy ? MEMWAIT : RUN;
            default: begin
               if (bus.mem_busy)  state_nxt = MEMWAIT;
               else if (load_use) state_nxt = LDUSE;
               else               state_nxt = RUN;
            end
         endcase
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      case (state)
         RUN: begin
            // Halt, memory wait or load-use this cycle suppress the flush;
            // the branch is re-resolved once the stall clears.
            ifid_flush = bus.branch_taken & ~bus.WB_halt & ~bus.mem_busy &
                         ~load_use;
         end
         LDUSE: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
         MEMWAIT: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
         default: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      endcase
   end

   // ID -> EX boundary: selects follow the instruction into EX.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_a_p1 <= '0;
         fwd_b_p1 <= '0;
      end else begin
         case (state)
            RUN: begin
               fwd_a_p1 <= sel_a;
               fwd_b_p1 <= sel_b;
            end
            LDUSE: begin
               fwd_a_p1 <= '0;
               fwd_b_p1 <= '0;
            end
            default: begin
               fwd_a_p1 <= fwd_a_p1;
               fwd_b_p1 <= fwd_b_p1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                  stall_cnt_q <= '0;
      else if (state == LDUSE || state == MEMWAIT) stall_cnt_q <= sat_inc(stall_cnt_q);
   end

   assign bus.ForwardA    = fwd_a_p1;
   assign bus.ForwardB    = fwd_b_p1;
   assign bus.pc_write    = pc_write;
   assign bus.ifid_write  = ifid_write;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign bus.halted      = (state == HALT);
   assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table covering forwarding,
// load-use and memory-wait sequences, plus hand-written halt, reset and
// counter-saturation sequences.
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   hazard_ctrl_if bus();

   hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in_f  = {EX_RegWrite, MEM_RegWrite, EX_MemRead, WB_halt, branch_taken, mem_busy}
   // out_f = {pc_write, ifid_write, ifid_flush, idex_bubble} during the cycle
   // fa/fb/cnt = registered values after the closing edge
   typedef struct {
      logic [15:0] instr;
      logic [3:0]  ex_rd;
      logic [3:0]  mem_rd;
      logic [5:0]  in_f;
      logic [3:0]  out_f;
      logic [2:0]  fa;
      logic [2:0]  fb;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] instr, input logic [3:0] ex_rd,
                        input logic [3:0] mem_rd, input logic [5:0] f);
      bus.ID_instr     = instr;
      bus.EX_rd        = ex_rd;
      bus.MEM_rd       = mem_rd;
      bus.EX_RegWrite  = f[5];
      bus.MEM_RegWrite = f[4];
      bus.EX_MemRead   = f[3];
      bus.WB_halt      = f[2];
      bus.branch_taken = f[1];
      bus.mem_busy     = f[0];
   endtask

   task automatic chk_ctl(input string tag, input logic [3:0] exp);
      chk({tag, " ctl"}, {28'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush,
                          bus.idex_bubble}, {28'd0, exp});
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      drive(16'h0000, 4'h0, 4'h0, 6'b000000);

      vecs[0]  = '{16'h1415, 4'h1, 4'h0, 6'b100000, 4'b1100, 3'b010, 3'b000, 16'd0};
      vecs[1]  = '{16'h1415, 4'h1, 4'h1, 6'b110000, 4'b1100, 3'b010, 3'b000, 16'd0};
      vecs[2]  = '{16'h1415, 4'h1, 4'h5, 6'b010000, 4'b1100, 3'b000, 3'b001, 16'd0};
      vecs[3]  = '{16'h0400, 4'h0, 4'h0, 6'b111000, 4'b1100, 3'b000, 3'b000, 16'd0};
      vecs[4]  = '{16'h9312, 4'h3, 4'h1, 6'b110000, 4'b1100, 3'b001, 3'b010, 16'd0};
      vecs[5]  = '{16'hA707, 4'h7, 4'h7, 6'b110000, 4'b1100, 3'b010, 3'b000, 16'd0};
      vecs[6]  = '{16'hC111, 4'h1, 4'h1, 6'b110000, 4'b1100, 3'b000, 3'b000, 16'd0};
      vecs[7]  = '{16'hA200, 4'h0, 4'h0, 6'b000010, 4'b1110, 3'b000, 3'b000, 16'd0};
      vecs[8]  = '{16'h0211, 4'h1, 4'h0, 6'b101010, 4'b1100, 3'b010, 3'b010, 16'd0};
      vecs[9]  = '{16'h0211, 4'h0, 4'h1, 6'b010000, 4'b0001, 3'b000, 3'b000, 16'd1};
      vecs[10] = '{16'h0211, 4'h0, 4'h1, 6'b010000, 4'b1100, 3'b001, 3'b001, 16'd1};
      vecs[11] = '{16'h0211, 4'h1, 4'h0, 6'b101001, 4'b1100, 3'b010, 3'b010, 16'd1};
      vecs[12] = '{16'h0211, 4'h1, 4'h0, 6'b101001, 4'b0000, 3'b010, 3'b010, 16'd2};
      vecs[13] = '{16'h0211, 4'h1, 4'h0, 6'b101011, 4'b0000, 3'b010, 3'b010, 16'd3};
      vecs[14] = '{16'h0211, 4'h1, 4'h0, 6'b101000, 4'b0000, 3'b010, 3'b010, 16'd4};
      vecs[15] = '{16'h0211, 4'h0, 4'h1, 6'b010000, 4'b0001, 3'b000, 3'b000, 16'd5};
      vecs[16] = '{16'h0211, 4'h0, 4'h1, 6'b010000, 4'b1100, 3'b001, 3'b001, 16'd5};

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst ForwardA", {29'd0, bus.ForwardA}, 32'd0);
      chk("rst ForwardB", {29'd0, bus.ForwardB}, 32'd0);
      chk("rst stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
      chk("rst halted", {31'd0, bus.halted}, 32'd0);
      chk_ctl("rst", 4'b1100);

      // Table-driven vectors
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].instr, vecs[i].ex_rd, vecs[i].mem_rd, vecs[i].in_f);
         #3;
         chk_ctl($sformatf("v%0d", i), vecs[i].out_f);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d ForwardA", i), {29'd0, bus.ForwardA}, {29'd0, vecs[i].fa});
         chk($sformatf("v%0d ForwardB", i), {29'd0, bus.ForwardB}, {29'd0, vecs[i].fb});
         chk($sformatf("v%0d stall_cnt", i), {16'd0, bus.stall_cnt}, {16'd0, vecs[i].cnt});
      end

      // Halt wins over a coincident branch, then sticks for 10 cycles
      drive(16'h0000, 4'h0, 4'h0, 6'b000110);
      #3;
      chk_ctl("halt entry", 4'b1100);
      @(posedge clk);
      #1;
      chk("halt set", {31'd0, bus.halted}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         drive(16'h0211, 4'h1, 4'h0, {5'b10100, i[0]});
         #3;
         chk($sformatf("halt hold %0d", i), {31'd0, bus.halted}, 32'd1);
         chk_ctl($sformatf("halt %0d", i), 4'b0001);
         @(posedge clk);
         #1;
      end
      chk("halt stall_cnt held", {16'd0, bus.stall_cnt}, 32'd5);
      drive(16'h0000, 4'h0, 4'h0, 6'b000000);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("halt clear", {31'd0, bus.halted}, 32'd0);
      chk("halt rst cnt", {16'd0, bus.stall_cnt}, 32'd0);
      chk("halt rst ForwardA", {29'd0, bus.ForwardA}, 32'd0);
      chk_ctl("after halt rst", 4'b1100);

      // Reset in the middle of a load-use stall leaves no bubble behind
      drive(16'h0211, 4'h1, 4'h0, 6'b101000);
      @(posedge clk);
      #1;
      chk_ctl("ldstall", 4'b0001);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      drive(16'h0000, 4'h0, 4'h0, 6'b000000);
      #1;
      chk_ctl("mid-stall rst", 4'b1100);
      chk("mid-stall rst cnt", {16'd0, bus.stall_cnt}, 32'd0);

      // Counter saturation through a long memory wait
      @(posedge clk);
      #1;
      drive(16'h0000, 4'h0, 4'h0, 6'b000001);
      repeat (65535) @(posedge clk);
      #1;
      chk("sat FFFE", {16'd0, bus.stall_cnt}, 32'h0000FFFE);
      repeat (3) @(posedge clk);
      #1;
      chk("sat FFFF", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
      chk_ctl("sat memwait", 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
